// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration interface: per-master requests, strobe/ready of the
// granted transfer, and the registered grant/error status from the arbiter.
interface bus_rr_arbiter_if #(
  parameter int N_MASTER = 4,
  parameter int ID_W     = 2
);
  logic [N_MASTER-1:0] req;
  logic                s_as;
  logic                s_rdy;
  logic [N_MASTER-1:0] grnt;
  logic                grnt_vld;
  logic [ID_W-1:0]     owner_id;
  logic                bus_err;
  logic [ID_W-1:0]     err_id;

  // Requesting side: masters plus the muxed strobe and slave ready
  modport master (
    output req, s_as, s_rdy,
    input  grnt, grnt_vld, owner_id, bus_err, err_id
  );

  // Arbiter side
  modport slave (
    input  req, s_as, s_rdy,
    output grnt, grnt_vld, owner_id, bus_err, err_id
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with a stall watchdog.
// An owner keeps the bus while it holds req; on release the grant hops
// straight to the next requester after the owner. A transfer stalled
// (s_as=1, s_rdy=0) for TIMEOUT consecutive cycles forces a one-cycle ERR
// state that drops the grant and pulses bus_err.
module bus_rr_arbiter #(
  parameter int N_MASTER = 4,
  parameter int TIMEOUT  = 255,
  parameter int ID_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  bus_rr_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_MASTER - 1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]          state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     err_id_q, err_id_nxt;
  logic [N_MASTER-1:0] grnt_q, grnt_nxt;
  logic                vld_q, vld_nxt;
  logic                err_q, err_nxt;
  logic [15:0]         to_cnt, to_cnt_nxt;
  logic                arb;
  logic [ID_W-1:0]     arb_from;
  logic [ID_W:0]       pick;

  // Increment modulo N_MASTER so ids never reach N_MASTER for odd sizes
  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] v);
    return (v == LAST_ID) ? '0 : v + ID_W'(1);
  endfunction

  // First requester at or after start, wrapping; returns {found, index}.
  // Walks backwards so the nearest requester is the last one written.
  function automatic logic [ID_W:0] rr_pick(input logic [N_MASTER-1:0] r,
                                            input logic [ID_W-1:0]     start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] sel;
    int              idx;
    res = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      sel = ID_W'(idx);
      if (r[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  // Next-state: arbitration on idle/error/release, watchdog while busy
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    grnt_nxt   = grnt_q;
    vld_nxt    = vld_q;
    err_nxt    = 1'b0;
    err_id_nxt = err_id_q;
    to_cnt_nxt = '0;
    arb        = 1'b0;
    arb_from   = ptr;
    pick       = '0;

    case (state)
      S_BUSY: begin
        if (!bus.req[owner]) begin
          // Release has priority over a timeout on the same edge
          arb      = 1'b1;
          arb_from = inc_wrap(owner);
          ptr_nxt  = inc_wrap(owner);
        end else if (bus.s_as && !bus.s_rdy) begin
          if (to_cnt == TO_LAST) begin
            state_nxt  = S_ERR;
            ptr_nxt    = inc_wrap(owner);
            grnt_nxt   = '0;
            vld_nxt    = 1'b0;
            err_nxt    = 1'b1;
            err_id_nxt = owner;
          end else begin
            to_cnt_nxt = to_cnt + 16'd1;
          end
        end
      end
      default: begin
        // IDLE and ERR share the same arbitration from ptr
        arb      = 1'b1;
        arb_from = ptr;
      end
    endcase

    if (arb) begin
      pick = rr_pick(bus.req, arb_from);
      if (pick[ID_W]) begin
        state_nxt = S_BUSY;
        owner_nxt = pick[ID_W-1:0];
        grnt_nxt  = N_MASTER'(1) << pick[ID_W-1:0];
        vld_nxt   = 1'b1;
      end else begin
        state_nxt = S_IDLE;
        grnt_nxt  = '0;
        vld_nxt   = 1'b0;
      end
    end
  end

  // State and output registers; reset drops the grant asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      err_id_q <= '0;
      grnt_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      err_id_q <= err_id_nxt;
      grnt_q   <= grnt_nxt;
      vld_q    <= vld_nxt;
      err_q    <= err_nxt;
      to_cnt   <= to_cnt_nxt;
    end
  end

  assign bus.grnt     = grnt_q;
  assign bus.grnt_vld = vld_q;
  assign bus.owner_id = owner;
  assign bus.bus_err  = err_q;
  assign bus.err_id   = err_id_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (N_MASTER=4, TIMEOUT=8). Each step
// pushes the expected outputs, clocks once and compares against the queue.
module tb_bus_rr_arbiter;

  typedef struct {
    logic [3:0] grnt;
    logic       vld;
    logic [1:0] owner;
    logic       err;
    logic [1:0] eid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [1:0] exp_owner = 2'd0;
  logic [1:0] exp_eid   = 2'd0;

  bus_rr_arbiter_if #(.N_MASTER(4), .ID_W(2)) bus ();

  bus_rr_arbiter #(.N_MASTER(4), .TIMEOUT(8), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] eg, input logic ee, input logic [1:0] eid);
    exp_t e;
    if (eg != 4'b0) exp_owner = oh2idx(eg);
    if (ee) exp_eid = eid;
    e.grnt  = eg;
    e.vld   = |eg;
    e.owner = exp_owner;
    e.err   = ee;
    e.eid   = exp_eid;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".grnt"},     32'(bus.grnt),     32'(e.grnt));
      chk({tag, ".grnt_vld"}, 32'(bus.grnt_vld), 32'(e.vld));
      chk({tag, ".owner_id"}, 32'(bus.owner_id), 32'(e.owner));
      chk({tag, ".bus_err"},  32'(bus.bus_err),  32'(e.err));
      chk({tag, ".err_id"},   32'(bus.err_id),   32'(e.eid));
    end
  endtask

  // Drive inputs (at a negedge), expect outputs after the next rising edge
  task automatic drive(input string tag, input logic [3:0] r, input logic as,
                       input logic rdy, input logic [3:0] eg, input logic ee,
                       input logic [1:0] eid);
    bus.req   = r;
    bus.s_as  = as;
    bus.s_rdy = rdy;
    push_exp(eg, ee, eid);
    @(posedge clk);
    #1;
    check_out(tag);
    @(negedge clk);
  endtask

  initial begin
    bus.req   = 4'b1111;
    bus.s_as  = 1'b0;
    bus.s_rdy = 1'b1;

    // Reset held with all masters requesting
    repeat (3) @(posedge clk);
    #1;
    push_exp(4'b0000, 1'b0, 2'd0);
    check_out("reset");

    // Release reset: master 0 granted one edge later
    @(negedge clk);
    rst = 1'b1;
    drive("rst_rel", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0);

    // Rotation with one-cycle releases, no idle gap
    drive("rot0", 4'b1110, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0);
    drive("hold1", 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0);
    drive("rot1", 4'b1101, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
    drive("hold2", 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
    drive("rot2", 4'b1011, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0);
    drive("hold3", 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0);
    drive("rot3", 4'b0111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0);

    // Release to idle, pointer moves past the old owner
    drive("to_idle", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    drive("ptr1", 4'b1001, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0);
    drive("idle2", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);

    // Single requester, grant held 20 cycles with s_rdy=1
    drive("grant2", 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++)
      drive("hold20", 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0);

    // 7 stalls, one ready cycle, then a full 8-stall run to timeout
    for (int i = 0; i < 7; i++)
      drive("stall7", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0);
    drive("rdy_clr", 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++)
      drive("restall", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0);
    drive("timeout", 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2);
    drive("err_exit", 4'b0101, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0);

    // Release on the timeout edge wins: no error, grant hops to master 2
    for (int i = 0; i < 7; i++)
      drive("pre_to", 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0);
    drive("rel_wins", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0);

    // Asynchronous reset while busy drops the grant without a clock edge
    #2;
    rst = 1'b0;
    #1;
    exp_owner = 2'd0;
    exp_eid   = 2'd0;
    push_exp(4'b0000, 1'b0, 2'd0);
    check_out("async_rst");

    // After release, arbitration restarts from pointer 0
    @(negedge clk);
    rst = 1'b1;
    drive("post_rst", 4'b0110, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter N_MASTER, default 4, number of bus masters (2..16).
REQ-002 Parameter TIMEOUT, default 255, number of consecutive stall cycles before a bus error (2..65535).
REQ-003 Parameter ID_W, default 2, owner index width; SHALL equal clog2(N_MASTER).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_MASTER  per-master bus request, level-held for the whole transfer.
REQ-007 s_as  input  1  active-high address strobe of the muxed (granted) master.
REQ-008 s_rdy  input  1  active-high ready from the selected slave.
REQ-009 grnt  output  N_MASTER  registered one-hot grant, or all-zero when no owner.
REQ-010 grnt_vld  output  1  high when grnt is nonzero.
REQ-011 owner_id  output  ID_W  index of the current owner; holds the last value when grnt_vld=0.
REQ-012 bus_err  output  1  one-cycle pulse on a watchdog timeout.
REQ-013 err_id  output  ID_W  index of the master whose grant timed out; valid while bus_err=1, holds otherwise.

Function
REQ-014 The block SHALL contain a three-state FSM: IDLE (no grant), BUSY (one grant), ERR (forced release).
REQ-015 The block SHALL keep a round-robin pointer ptr (ID_W bits); the search order is ptr, ptr+1, ... wrapping mod N_MASTER.
REQ-016 IDLE: if req!=0, the first requester in search order SHALL be granted at the next edge and the FSM SHALL go to BUSY; if req=0, the FSM SHALL stay in IDLE with grnt=0.
REQ-017 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to grnt high.
REQ-018 BUSY with req[owner]=1: the grant SHALL be held, with no preemption by any other request.
REQ-019 BUSY with req[owner]=0 and other requests pending: at that same edge, ptr SHALL become owner+1 mod N_MASTER and the grant SHALL move directly to the first requester from owner+1, with no idle cycle.
REQ-020 BUSY with req[owner]=0 and no other request: the FSM SHALL go to IDLE, set grnt=0 and set ptr to owner+1 mod N_MASTER.
REQ-021 The 16-bit watchdog counter to_cnt SHALL increment each BUSY cycle with s_as=1 and s_rdy=0, and SHALL clear otherwise, on any grant change, and in IDLE/ERR.
REQ-022 When the FSM is in BUSY, s_as=1, s_rdy=0 and to_cnt=TIMEOUT-1 at an edge, the FSM SHALL go to ERR, i.e. the error fires after TIMEOUT consecutive stall cycles.
REQ-023 ERR SHALL last exactly 1 cycle with grnt=0, grnt_vld=0, bus_err=1 and err_id=timed-out owner; at entry, ptr SHALL be set to owner+1.
REQ-024 ERR exit SHALL follow the IDLE arbitration rules; the offending master may be re-granted only in round-robin order.
REQ-025 If req[owner] drops on the same edge the timeout would fire, the release SHALL win: no bus_err, and REQ-019/020 apply.
REQ-026 Wrap-around: ptr SHALL wrap from N_MASTER-1 to 0; when N_MASTER is not a power of two, ptr and owner SHALL never take values of N_MASTER or above.
REQ-027 grnt, grnt_vld, owner_id, bus_err and err_id SHALL be driven directly from registers, with no combinational path from req.

Reset
REQ-028 While rst=0: state=IDLE, grnt=0, grnt_vld=0, owner_id=0, ptr=0, to_cnt=0, bus_err=0, err_id=0.
REQ-029 Reset asserted during BUSY or ERR SHALL drop grnt to 0 immediately (asynchronously); the first grant after release SHALL follow REQ-016.

Verification (N_MASTER=4, TIMEOUT=8)
REQ-030 rst low while req=1111 -> grnt=0000 and bus_err=0; rst high -> grnt=0001 one edge later.
REQ-031 req=0100 from IDLE -> grnt=0100, owner_id=2 after 1 edge; grant held for 20 cycles while req[2]=1 and s_rdy=1.
REQ-032 req=1111 held, each owner releases its request for 1 cycle in turn -> grant order 0001, 0010, 0100, 1000, 0001 with no grnt=0 cycle between owners.
REQ-033 Owner 0 releases with req=0000 -> grnt=0000; then req=1001 -> grnt=1000 (ptr=1).
REQ-034 Owner 2, s_as=1, s_rdy=0 for 8 cycles -> bus_err=1 for one cycle, err_id=2, grnt=0000; with req=0101 -> next grnt=0001.
REQ-035 Owner 2 stalled 7 cycles, then s_rdy=1 for one cycle, then stalled again -> no bus_err until 8 further stall cycles have elapsed.
